// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a per-bit oversampling counter.
// Recovers each byte LSB first, flags framing errors and overruns, and
// presents received bytes on a level valid / ack handshake.
//
// Handshake: valid rises the cycle after a good stop bit is sampled and
// stays high until the cycle after ack is seen high while valid is high.
// ack while valid is low has no effect. If a frame completes while valid
// is already high, data is overwritten and overrun is set. The one exception
// is when ack arrives in that same cycle: the old byte counts as consumed,
// so valid stays high with the new byte and no overrun is raised.
// overrun is sticky until reset.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic [7:0]             shift, shift_nxt;
  logic [7:0]             data_nxt;
  logic                   valid_nxt;
  logic                   overrun_nxt;
  logic                   frame_err_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Synchroniser chain plus one delayed copy for falling-edge detection;
  // both reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q[0] <= rxd;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rx_prev <= rx_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      overrun   <= overrun_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Next-state, bit sampling and handshake logic.
  // The start-bit sample lands HALF cycles after the edge-detect cycle, so
  // START is entered with cnt already at 1. With HALF == 0 the detect cycle
  // itself is the start sample, and rx_s is known low there.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift;
    data_nxt      = data;
    valid_nxt     = valid;
    overrun_nxt   = overrun;
    frame_err_nxt = 1'b0;

    if (ack && valid) begin
      valid_nxt = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          bit_idx_nxt = '0;
          if (HALF == '0) begin
            state_nxt = S_DATA;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_START;
            cnt_nxt   = ONE;
          end
        end
      end

      S_START: begin
        if (cnt == HALF) begin
          if (!rx_s) begin
            state_nxt   = S_DATA;
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end

      S_DATA: begin
        if (cnt == LAST) begin
          shift_nxt[bit_idx] = rx_s;
          cnt_nxt            = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end

      S_STOP: begin
        if (cnt == LAST) begin
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            if (valid && !ack) begin
              overrun_nxt = 1'b1;
            end
            state_nxt = S_IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = S_BRK;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end

      S_BRK: begin
        // Hold here until the line is released, so a stuck-low line
        // cannot be mistaken for a new start bit.
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a simple timing/byte
// model for uart_rx (CLKS_PER_BIT=16, SYNC_STAGES=2).
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SS   = 2;
  localparam int HALF = CPB / 2;
  localparam int LAT  = SS + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int fall_g = 0;
  int n_wait = 0;

  int         fall_q[$];
  int         rise_q[$];
  int         fe_q[$];
  logic [7:0] data_q[$];
  logic [7:0] exp_q[$];

  logic       valid_d = 1'b0;
  logic [7:0] last_byte;
  logic [7:0] b1, b2;
  bit         ok1, ok2;
  int         gap;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .ack       (ack),
    .data      (data),
    .valid     (valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: valid rising edges (with byte) and frame_err pulses
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1 && valid_d !== 1'b1) begin
      rise_q.push_back(cyc);
      data_q.push_back(data);
    end
    if (frame_err === 1'b1) fe_q.push_back(cyc);
    valid_d = valid;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    fall_q.delete();
    rise_q.delete();
    fe_q.delete();
    data_q.delete();
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; caller is at a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall_g = cyc;
    fall_q.push_back(cyc);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic ack_when_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        ok = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    rxd = 1'b1;
    ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    idle(CPB);

    // 1: single frame 0x61, latency and ack
    clear_events();
    send_frame(8'h61, 1'b1);
    idle(CPB);
    check("t1_rises", rise_q.size(), 1);
    check("t1_latency", (rise_q.size() > 0) ? rise_q[0] - fall_q[0] : -1, LAT);
    check("t1_data", data, 8'h61);
    check("t1_valid", valid, 1'b1);
    check("t1_no_fe", fe_q.size(), 0);
    ack_pulse();
    check("t1_ack_clears", valid, 1'b0);
    check("t1_data_held", data, 8'h61);

    // 2: back-to-back frames, acked as they arrive
    clear_events();
    fork
      begin
        send_frame(8'h61, 1'b1);
        send_frame(8'hD9, 1'b1);
      end
      begin
        ack_when_valid(ok1);
        ack_when_valid(ok2);
      end
    join
    idle(4);
    check("t2_ack1_seen", ok1, 1'b1);
    check("t2_ack2_seen", ok2, 1'b1);
    check("t2_rises", rise_q.size(), 2);
    check("t2_data0", (data_q.size() > 0) ? data_q[0] : 8'hxx, 8'h61);
    check("t2_data1", (data_q.size() > 1) ? data_q[1] : 8'hxx, 8'hD9);
    check("t2_latency1", (rise_q.size() > 1) ? rise_q[1] - fall_q[1] : -1, LAT);
    check("t2_overrun", overrun, 1'b0);
    check("t2_valid", valid, 1'b0);

    // Randomized frames with random idle gaps, each acked
    clear_events();
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      gap = $urandom_range(0, 3 * CPB);
      idle(gap);
      b1 = 8'($urandom_range(0, 255));
      exp_q.push_back(b1);
      last_byte = b1;
      send_frame(b1, 1'b1);
      idle(2);
      check("rand_valid", valid, 1'b1);
      ack_pulse();
    end
    check("rand_count", data_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("rand_data", (data_q.size() > k) ? data_q[k] : 8'hxx, exp_q[k]);
      check("rand_latency", (rise_q.size() > k) ? rise_q[k] - fall_q[k] : -1, LAT);
    end
    check("rand_overrun", overrun, 1'b0);

    // 3: short low glitch is rejected
    clear_events();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    check("t3_busy_start", busy, 1'b1);
    idle(3 * CPB);
    check("t3_busy_drops", busy, 1'b0);
    check("t3_no_valid", valid, 1'b0);
    check("t3_no_rise", rise_q.size(), 0);
    check("t3_data_kept", data, last_byte);

    // 4: bad stop bit, held-low line, then recovery
    clear_events();
    send_frame(8'h55, 1'b0);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_fe_pulses", fe_q.size(), 1);
    check("t4_fe_latency", (fe_q.size() > 0) ? fe_q[0] - fall_q[0] : -1, LAT);
    check("t4_frame_err_low", frame_err, 1'b0);
    check("t4_valid", valid, 1'b0);
    check("t4_data_kept", data, last_byte);
    check("t4_busy_break", busy, 1'b1);
    check("t4_no_rise", rise_q.size(), 0);
    idle(CPB);
    check("t4_break_exit", busy, 1'b0);
    send_frame(8'h3C, 1'b1);
    idle(4);
    check("t4_data_3c", data, 8'h3C);
    check("t4_valid_3c", valid, 1'b1);
    check("t4_rises", rise_q.size(), 1);
    ack_pulse();

    // ack in the completion cycle: new byte, valid stays high, no overrun
    clear_events();
    b1 = 8'($urandom_range(0, 255));
    b2 = b1 ^ (8'h01 | 8'($urandom_range(0, 255)));
    send_frame(b1, 1'b1);
    idle(4);
    check("sc_valid_first", valid, 1'b1);
    fork
      send_frame(b2, 1'b1);
      begin
        n_wait = 0;
        @(negedge clk);
        while (cyc != fall_g + LAT - 1 && n_wait < 400) begin
          @(negedge clk);
          n_wait++;
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    idle(4);
    check("sc_timing_reached", n_wait < 400, 1'b1);
    check("sc_data", data, b2);
    check("sc_valid", valid, 1'b1);
    check("sc_overrun", overrun, 1'b0);
    ack_pulse();
    check("sc_ack_clears", valid, 1'b0);

    // 5: two frames without ack -> overrun
    clear_events();
    send_frame(8'hA5, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle(4);
    check("t5_data", data, 8'h5A);
    check("t5_valid", valid, 1'b1);
    check("t5_overrun", overrun, 1'b1);
    check("t5_rises", rise_q.size(), 1);
    ack_pulse();
    check("t5_ack_clears", valid, 1'b0);
    check("t5_overrun_sticky", overrun, 1'b1);
    ack_pulse();
    check("t5_ack_idle_ignored", valid, 1'b0);

    // 6: asynchronous reset in the middle of data bit 4
    clear_events();
    b1 = 8'($urandom_range(0, 255));
    fork
      send_frame(b1, 1'b1);
      begin
        repeat (5 * CPB + HALF) @(negedge clk);
        check("t6_busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("t6_data", data, 8'h00);
        check("t6_valid", valid, 1'b0);
        check("t6_overrun", overrun, 1'b0);
        check("t6_frame_err", frame_err, 1'b0);
        check("t6_busy", busy, 1'b0);
      end
    join
    idle(CPB);
    rst = 1'b1;
    idle(CPB);
    check("t6_no_phantom", rise_q.size(), 0);
    clear_events();
    send_frame(8'hFF, 1'b1);
    idle(4);
    check("t6_data_ff", data, 8'hFF);
    check("t6_valid_ff", valid, 1'b1);
    check("t6_overrun_ff", overrun, 1'b0);
    check("t6_latency_ff", (rise_q.size() > 0) ? rise_q[0] - fall_q[0] : -1, LAT);
    ack_pulse();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
